// File: rtl/lc3b_mem_iface_pkg.sv
// Shared types for the LC-3b memory-interface unit: FSM state enum and default widths.
package lc3b_types;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 16;

    typedef enum logic [1:0] {
        MI_IDLE   = 2'd0,
        MI_ACCESS = 2'd1,
        MI_RESP   = 2'd2
    } lc3b_mem_iface_state;

endpackage

// File: rtl/lc3b_mem_iface_if.sv
// Request/response and memory-port bundle of the LC-3b memory-interface unit.
interface lc3b_mem_iface_if
    import lc3b_types::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) ();
    localparam int LANES = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_byte;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [LANES-1:0]  mem_byte_enable;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_resp;

    // slave: the access engine; master: control path plus memory model
    modport slave (
        input  req_valid, req_write, req_byte, req_addr, req_wdata, mem_rdata, mem_resp,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_byte, req_addr, req_wdata, mem_rdata, mem_resp,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata
    );

endinterface

// File: rtl/lc3b_mem_iface_byte_lane.sv
// Byte-lane helpers: lane extract with zero-extension, byte replication, one-hot lane enable.
module byte_lane
    import lc3b_types::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int LANES  = DATA_W / 8,
    parameter int BSEL_W = $clog2(LANES)
) (
    input  logic [BSEL_W-1:0] i_lane_sel,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [7:0]        i_wbyte,
    output logic [DATA_W-1:0] o_lane_zext,
    output logic [DATA_W-1:0] o_repl,
    output logic [LANES-1:0]  o_onehot
);
    logic [7:0] w_lanes [LANES];

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign w_lanes[gi]          = i_rdata[gi*8 +: 8];
        assign o_repl[gi*8 +: 8]    = i_wbyte;
        assign o_onehot[gi]         = (i_lane_sel == BSEL_W'(gi));
    end

    assign o_lane_zext = {{(DATA_W-8){1'b0}}, w_lanes[i_lane_sel]};

endmodule

// File: rtl/lc3b_mem_iface.sv
// Handshaked byte-aware MAR/MDR access engine for the LC-3b multicycle core.
// Optional access timeout enabled by defining MEM_IFACE_TIMEOUT_EN.
module lc3b_mem_iface
    import lc3b_types::*;
#(
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int ADDR_W         = DEFAULT_ADDR_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic             clk,
    input logic             rst_n,
    lc3b_mem_iface_if.slave bus
);
    localparam int LANES  = DATA_W / 8;
    localparam int BSEL_W = $clog2(LANES);

    lc3b_mem_iface_state r_state, w_state_next;
    logic [ADDR_W-1:0]   r_mar;
    logic [DATA_W-1:0]   r_mdr;
    logic                r_write;
    logic                r_byte;
    logic                r_err;
    logic                w_timeout;
    logic [DATA_W-1:0]   w_lane_zext;
    logic [DATA_W-1:0]   w_repl;
    logic [LANES-1:0]    w_onehot;
    logic                w_accept;

    byte_lane #(.DATA_W(DATA_W)) u_byte_lane (
        .i_lane_sel  (r_mar[BSEL_W-1:0]),
        .i_rdata     (bus.mem_rdata),
        .i_wbyte     (bus.req_wdata[7:0]),
        .o_lane_zext (w_lane_zext),
        .o_repl      (w_repl),
        .o_onehot    (w_onehot)
    );

    assign w_accept = (r_state == MI_IDLE) && bus.req_valid;

`ifdef MEM_IFACE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (r_state == MI_ACCESS && !bus.mem_resp) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // The last waiting cycle is the one where the count is about to reach the limit
    assign w_timeout = (r_state == MI_ACCESS) && !bus.mem_resp
                       && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // No timer: ACCESS waits for mem_resp forever; the parameter is inert here
    assign w_timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MI_IDLE;
            r_mar   <= '0;
            r_mdr   <= '0;
            r_write <= 1'b0;
            r_byte  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_mar   <= bus.req_addr;
                r_write <= bus.req_write;
                r_byte  <= bus.req_byte;
                r_mdr   <= (bus.req_write && bus.req_byte) ? w_repl : bus.req_wdata;
                r_err   <= 1'b0;
            end else if (r_state == MI_ACCESS) begin
                if (bus.mem_resp) begin
                    if (!r_write) begin
                        r_mdr <= r_byte ? w_lane_zext : bus.mem_rdata;
                    end
                end else if (w_timeout) begin
                    r_mdr <= '0;
                    r_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            MI_IDLE:   if (bus.req_valid) w_state_next = MI_ACCESS;
            MI_ACCESS: if (bus.mem_resp || w_timeout) w_state_next = MI_RESP;
            MI_RESP:   w_state_next = MI_IDLE;
            default:   w_state_next = MI_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready       = (r_state == MI_IDLE);
        bus.rsp_valid       = (r_state == MI_RESP);
        bus.rsp_rdata       = r_mdr;
        bus.rsp_err         = r_err;
        bus.mem_read        = (r_state == MI_ACCESS) && !r_write;
        bus.mem_write       = (r_state == MI_ACCESS) && r_write;
        bus.mem_wdata       = r_mdr;
        bus.mem_address     = r_byte ? r_mar : {r_mar[ADDR_W-1:BSEL_W], {BSEL_W{1'b0}}};
        bus.mem_byte_enable = '0;
        if (r_state == MI_ACCESS) begin
            bus.mem_byte_enable = r_byte ? w_onehot : '1;
        end
    end

endmodule

// File: tb/tb_lc3b_mem_iface.sv
// Directed bench for lc3b_mem_iface: word/byte loads and stores, backpressure, reset, timeout.
module tb_lc3b_mem_iface;
    import lc3b_types::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    lc3b_mem_iface_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    lc3b_mem_iface #(.DATA_W(16), .ADDR_W(16), .TIMEOUT_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the unit idle. delay = ACCESS cycles before mem_resp (-1: never);
    // n_acc = ACCESS cycles expected before RESP.
    task automatic run_access(input string tag, input bit wr, input bit by,
                              input logic [15:0] addr, input logic [15:0] wdata,
                              input logic [15:0] rdata, input int delay, input int n_acc,
                              input logic [15:0] exp_addr, input logic [1:0] exp_be,
                              input logic [15:0] exp_wd, input logic [15:0] exp_rd,
                              input bit exp_err, input bit hold_valid);
        check({tag, ".ready_idle"}, bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_byte  = by;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        if (!hold_valid) bus.req_valid = 1'b0;
        for (int c = 1; c <= n_acc; c++) begin
            check($sformatf("%s.c%0d.read", tag, c), bus.mem_read, !wr);
            check($sformatf("%s.c%0d.write", tag, c), bus.mem_write, wr);
            check($sformatf("%s.c%0d.addr", tag, c), bus.mem_address, exp_addr);
            check($sformatf("%s.c%0d.be", tag, c), bus.mem_byte_enable, exp_be);
            check($sformatf("%s.c%0d.ready", tag, c), bus.req_ready, 0);
            check($sformatf("%s.c%0d.rsp_valid", tag, c), bus.rsp_valid, 0);
            if (wr) check($sformatf("%s.c%0d.wdata", tag, c), bus.mem_wdata, exp_wd);
            if (c == delay + 1) begin
                bus.mem_resp  = 1'b1;
                bus.mem_rdata = rdata;
            end
            @(negedge clk);
            bus.mem_resp  = 1'b0;
            bus.mem_rdata = 16'hDEAD;
        end
        check({tag, ".rsp_valid"}, bus.rsp_valid, 1);
        check({tag, ".rsp_err"}, bus.rsp_err, exp_err);
        check({tag, ".rsp_ready"}, bus.req_ready, 0);
        check({tag, ".rsp_strobes"}, {bus.mem_read, bus.mem_write}, 2'b00);
        if (!wr) check({tag, ".rdata"}, bus.rsp_rdata, exp_rd);
        @(negedge clk);
        check({tag, ".rsp_drop"}, bus.rsp_valid, 0);
        check({tag, ".ready_after"}, bus.req_ready, 1);
        $display("txn %-10s wr=%0d byte=%0d addr=0x%04h rdata=0x%04h err=%0d",
                 tag, wr, by, addr, bus.rsp_rdata, bus.rsp_err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_byte  = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = 16'hDEAD;
        repeat (2) @(negedge clk);
        check("rst.ready", bus.req_ready, 1);
        check("rst.rsp_valid", bus.rsp_valid, 0);
        check("rst.rsp_err", bus.rsp_err, 0);
        check("rst.strobes", {bus.mem_read, bus.mem_write}, 2'b00);
        check("rst.be", bus.mem_byte_enable, 0);
        check("rst.addr", bus.mem_address, 0);
        check("rst.wdata", bus.mem_wdata, 0);
        check("rst.rdata", bus.rsp_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        //          tag       wr by addr      wdata     rdata     dly nacc exp_addr  be     exp_wd    exp_rd    err hold
        run_access("wload",   0, 0, 16'h3001, 16'hFFFF, 16'hBEEF, 1,  2,   16'h3000, 2'b11, 16'h0000, 16'hBEEF, 0, 0);
        run_access("bload_hi",0, 1, 16'h3001, 16'hFFFF, 16'hBEEF, 1,  2,   16'h3001, 2'b10, 16'h0000, 16'h00BE, 0, 0);
        run_access("bload_lo",0, 1, 16'h3000, 16'hFFFF, 16'hBEEF, 0,  1,   16'h3000, 2'b01, 16'h0000, 16'h00EF, 0, 0);
        run_access("bstore",  1, 1, 16'h4000, 16'h12A5, 16'h0000, 2,  3,   16'h4000, 2'b01, 16'hA5A5, 16'h0000, 0, 0);
        run_access("bstore_hi",1,1, 16'h4001, 16'h0077, 16'h0000, 0,  1,   16'h4001, 2'b10, 16'h7777, 16'h0000, 0, 0);
        run_access("wstore",  1, 0, 16'h4003, 16'h5A3C, 16'h0000, 0,  1,   16'h4002, 2'b11, 16'h5A3C, 16'h0000, 0, 0);
        // Backpressure: request held high across a 10-cycle wait, second one follows right after
        run_access("bp_load", 0, 0, 16'h5002, 16'hFFFF, 16'h1234, 10, 11,  16'h5002, 2'b11, 16'h0000, 16'h1234, 0, 1);
        run_access("bp_next", 0, 1, 16'h5003, 16'hFFFF, 16'hC3A0, 0,  1,   16'h5003, 2'b10, 16'h0000, 16'h00C3, 0, 0);

        // Reset in the second ACCESS cycle of a byte load
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_byte  = 1'b1;
        bus.req_addr  = 16'h3000;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rstmid.c1.read", bus.mem_read, 1);
        @(negedge clk);
        check("rstmid.c2.read", bus.mem_read, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid.read_drop", bus.mem_read, 0);
        check("rstmid.be_drop", bus.mem_byte_enable, 0);
        check("rstmid.ready", bus.req_ready, 1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("rstmid.held%0d.rsp_valid", c), bus.rsp_valid, 0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rstmid.rel%0d.rsp_valid", c), bus.rsp_valid, 0);
            check($sformatf("rstmid.rel%0d.ready", c), bus.req_ready, 1);
        end
        check("rstmid.rdata", bus.rsp_rdata, 0);
        $display("txn %-10s reset asserted mid-access", "rstmid");

        run_access("post_rst",0, 0, 16'h6000, 16'hFFFF, 16'h0F0F, 0,  1,   16'h6000, 2'b11, 16'h0000, 16'h0F0F, 0, 0);

`ifdef MEM_IFACE_TIMEOUT_EN
        run_access("tmo",     0, 0, 16'h7000, 16'hFFFF, 16'h0000, -1, 4,   16'h7000, 2'b11, 16'h0000, 16'h0000, 1, 0);
        run_access("tmo_edge",0, 0, 16'h7002, 16'hFFFF, 16'h8001, 3,  4,   16'h7002, 2'b11, 16'h0000, 16'h8001, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lc3b_mem_iface.md
# lc3b_mem_iface

Parametrised memory-interface unit for the LC-3b multicycle core. It replaces the bare MAR/MDR register pair with a handshaked, byte-aware access engine. It accepts one load/store request at a time from the control path, drives the memory port with stable strobes until `mem_resp`, and returns a single-cycle response. Generalised in data/address width, it adds byte accesses (LDB/STB lane steering) and an optional access timeout.

## Interface
- `DATA_W`, 16: data width in bits; a multiple of 8, ≥16, power-of-two byte count. `LANES = DATA_W/8`, `BSEL_W = $clog2(LANES)`.
- `ADDR_W`, 16: byte-address width.
- `TIMEOUT_CYCLES`, 255: maximum cycles spent in ACCESS. Used only under `MEM_IFACE_TIMEOUT_EN`.

- `clk` in 1: single clock; everything samples on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_byte` in 1: 1 = byte access, 0 = word access.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in DATA_W: store data; for byte stores only bits [7:0] are used.
- `rsp_valid` out 1: response pulse, exactly one cycle.
- `rsp_rdata` out DATA_W: load data; zero-extended for byte loads.
- `rsp_err` out 1: access timed out; qualified by `rsp_valid`.
- `mem_address` out ADDR_W: memory address.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `mem_byte_enable` out LANES: lane write enables.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data.
- `mem_resp` in 1: memory has completed the access.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE.** `req_ready`=1. On `req_valid && req_ready`, latch the following and go to ACCESS:
  - MAR ← `req_addr`.
  - Write flag and byte flag.
  - MDR ← `req_wdata`. For a byte store, `req_wdata[7:0]` is replicated into every lane.
- **ACCESS.** `req_ready`=0.
  - `mem_read` = !write; `mem_write` = write. Strobes, address, data and enables stay constant until exit.
  - `mem_address` = MAR for byte accesses. For word accesses, MAR with the low BSEL_W bits forced to 0.
  - `mem_byte_enable` = all ones for word accesses; one-hot at lane MAR[BSEL_W-1:0] for byte accesses.
  - On `mem_resp`:
    - For loads, MDR ← `mem_rdata` (word), or the selected lane zero-extended (byte).
    - Go to RESP.
- **RESP.** `rsp_valid`=1, `rsp_rdata`=MDR, `req_ready`=0, both strobes 0. Go to IDLE unconditionally.
- `rsp_rdata` holds MDR in every state. After a store response its value is don't-care.
- `mem_resp` in IDLE or RESP is ignored.
- `req_valid` while busy is not accepted. The requester holds the request until it sees `req_ready`.

## Timing
- Reset values:
  - State IDLE; MAR=0; MDR=0; timeout counter=0.
  - `req_ready`=1, `rsp_valid`=0, `rsp_err`=0, `mem_read`=0, `mem_write`=0.
  - `mem_byte_enable`=0, `mem_address`=0, `mem_wdata`=0.
- Reset is asynchronous. Asserting `rst_n` low mid-ACCESS drops the strobes immediately, with no clock edge needed. The in-flight access is abandoned and no response is issued.
- Accept at edge k → strobes high in cycle k+1.
- `mem_resp` sampled high at edge m → `rsp_valid` high in cycle m+1 → `req_ready` high in cycle m+2.
- Minimum accept-to-response latency: 2 cycles (`mem_resp` present in the first ACCESS cycle).
- Maximum throughput: one access per 3 cycles.

## Configuration
- `MEM_IFACE_TIMEOUT_EN` defined:
  - A counter of width `$clog2(TIMEOUT_CYCLES+1)` clears on entry to ACCESS and increments every ACCESS cycle without `mem_resp`.
  - When it reaches TIMEOUT_CYCLES: strobes drop, go to RESP with `rsp_err`=1 and MDR ← 0.
  - If `mem_resp` coincides with the terminal count, `mem_resp` wins and `rsp_err`=0.
- Undefined: no counter is built; ACCESS waits indefinitely; `rsp_err` is tied to 0.

## Structure
- Add to `lc3b_types`:
  - the state enum `lc3b_mem_iface_state`;
  - the default width constants for `DATA_W` and `ADDR_W`.
- One sub-module: `byte_lane` (combinational, parameterised by `DATA_W`). It provides:
  - lane extract with zero-extension;
  - byte replication;
  - one-hot enable decode from the lane select.

## Test plan
Default parameters (`DATA_W`=16, `ADDR_W`=16) unless stated.
- **Word load.** Addr 0x3001, `mem_rdata` 0xBEEF, `mem_resp` one cycle after the strobe → `mem_address`=0x3000, `mem_byte_enable`=2'b11, `rsp_rdata`=0xBEEF; `rsp_valid` 3 cycles after accept, held for one cycle.
- **Byte load.** Addr 0x3001, `mem_rdata` 0xBEEF → `mem_byte_enable`=2'b10, `rsp_rdata`=0x00BE. Repeat at addr 0x3000 → 0x00EF.
- **Byte store.** Addr 0x4000, `req_wdata` 0x12A5 → `mem_wdata`=0xA5A5, `mem_byte_enable`=2'b01, `mem_write` held until `mem_resp`.
- **Backpressure.** `mem_resp` delayed 10 cycles with `req_valid` held high throughout → `req_ready`=0; strobes and address unchanged every cycle; second request accepted only in the cycle after `rsp_valid`.
- **Reset mid-op.** Drop `rst_n` in the 2nd ACCESS cycle → `mem_read`=0 immediately; no `rsp_valid`; `req_ready`=1 after release.
- **Timeout** (with `MEM_IFACE_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4).
  - No `mem_resp` → `rsp_err`=1, `rsp_rdata`=0 after 4 ACCESS cycles.
  - `mem_resp` on the 4th cycle → `rsp_err`=0.
